// File: rtl/ifu_refill_ctrl.sv
// ----------------------------------------------------------------------------
// ifu_refill_ctrl
//
// Miss-refill engine that sits directly behind the instruction cache. It takes
// the cache's miss tag, fetches the line as BEATS sequential word reads over a
// 32-bit valid/ready memory port, assembles the line, and hands it back to the
// cache with a one-cycle valid strobe. Only one refill is in flight at a time.
// A watchdog aborts a refill that stalls for too long without a response beat.
//
// Ports:
//   Clock                   - single clock
//   Rst                     - synchronous, active-high reset
//   cache_reqTagIn          - miss tag from the cache
//   cache_reqTagValidIn     - level-sensitive miss request
//   mem_rspTagOut           - tag of the returned line (holds last value)
//   mem_rspInsLineOut       - assembled line (holds last value)
//   mem_rspInsLineValidOut  - one-cycle line-valid pulse
//   rd_reqValidOut          - word read request valid
//   rd_reqAddrOut           - word byte address (0 when no request)
//   rd_reqReadyIn           - memory accepts the request
//   rd_rspValidIn           - read data beat valid (in order, no backpressure)
//   rd_rspDataIn            - read data
//   refill_busyOut          - high whenever the engine is not idle
//   refill_errOut           - one-cycle timeout pulse
// ----------------------------------------------------------------------------
module ifu_refill_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int OFFSET_WIDTH   = 4,
    parameter int TAG_WIDTH      = ADDR_WIDTH - OFFSET_WIDTH,
    parameter int LINE_WIDTH     = 128,
    parameter int WORD_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  Clock,
    input  logic                  Rst,
    input  logic [TAG_WIDTH-1:0]  cache_reqTagIn,
    input  logic                  cache_reqTagValidIn,
    output logic [TAG_WIDTH-1:0]  mem_rspTagOut,
    output logic [LINE_WIDTH-1:0] mem_rspInsLineOut,
    output logic                  mem_rspInsLineValidOut,
    output logic                  rd_reqValidOut,
    output logic [ADDR_WIDTH-1:0] rd_reqAddrOut,
    input  logic                  rd_reqReadyIn,
    input  logic                  rd_rspValidIn,
    input  logic [WORD_WIDTH-1:0] rd_rspDataIn,
    output logic                  refill_busyOut,
    output logic                  refill_errOut
);

    localparam int BEATS     = LINE_WIDTH / WORD_WIDTH;
    localparam int IDX_WIDTH = $clog2(BEATS);
    localparam int CNT_WIDTH = IDX_WIDTH + 1;
    localparam int BYTE_SEL  = OFFSET_WIDTH - IDX_WIDTH;
    localparam int TO_WIDTH  = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [CNT_WIDTH-1:0] BEATS_C     = CNT_WIDTH'(BEATS);
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT_C = CNT_WIDTH'(BEATS - 1);
    localparam logic [TO_WIDTH-1:0]  TO_LAST_C   = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE,
        HOLD
    } stateT;

    stateT                                 state;
    stateT                                 nextState;
    logic [TAG_WIDTH-1:0]                  curTag;
    logic [CNT_WIDTH-1:0]                  issueCnt;
    logic [CNT_WIDTH-1:0]                  rcvCnt;
    logic [TO_WIDTH-1:0]                   toCnt;
    logic [BEATS-1:0][WORD_WIDTH-1:0]      lineBuf;
    logic [BEATS-1:0][WORD_WIDTH-1:0]      lineNext;
    logic [TAG_WIDTH-1:0]                  rspTag;
    logic [BEATS-1:0][WORD_WIDTH-1:0]      rspLine;
    logic                                  reqValid;
    logic [ADDR_WIDTH-1:0]                 reqAddr;
    logic                                  lineValid;
    logic                                  timeoutErr;

    // The line buffer with the current response beat dropped into its slot.
    // On the final beat this is the complete line, so the output registers can
    // capture it in the same edge that moves the FSM into DONE.
    always_comb begin
        lineNext = lineBuf;
        lineNext[rcvCnt[IDX_WIDTH-1:0]] = rd_rspDataIn;
    end

    // Next-state and output decode. Requests keep issuing while fewer than
    // BEATS have been accepted; responses may overlap with issue. A response
    // beat in the same cycle as the watchdog limit wins over the timeout.
    always_comb begin
        nextState  = state;
        reqValid   = 1'b0;
        reqAddr    = '0;
        lineValid  = 1'b0;
        timeoutErr = 1'b0;
        case (state)
            IDLE: begin
                if (cache_reqTagValidIn) begin
                    nextState = FETCH;
                end
            end
            FETCH: begin
                if (issueCnt < BEATS_C) begin
                    reqValid = 1'b1;
                    reqAddr  = {curTag, issueCnt[IDX_WIDTH-1:0], {BYTE_SEL{1'b0}}};
                end
                if (rd_rspValidIn) begin
                    if (rcvCnt == LAST_BEAT_C) begin
                        nextState = DONE;
                    end
                end else if (toCnt == TO_LAST_C) begin
                    timeoutErr = 1'b1;
                    nextState  = HOLD;
                end
            end
            DONE: begin
                lineValid = 1'b1;
                nextState = HOLD;
            end
            HOLD: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // State register plus the datapath: tag latch on accept, issue/receive
    // counters, watchdog, and line assembly. Counters and the partial line are
    // cleared when a new refill is accepted so an aborted refill never leaks
    // into the next one. The returned tag/line are only updated on the final
    // beat so they hold their last values outside DONE.
    always_ff @(posedge Clock) begin
        if (Rst) begin
            state    <= IDLE;
            curTag   <= '0;
            issueCnt <= '0;
            rcvCnt   <= '0;
            toCnt    <= '0;
            lineBuf  <= '0;
            rspTag   <= '0;
            rspLine  <= '0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (cache_reqTagValidIn) begin
                        curTag   <= cache_reqTagIn;
                        issueCnt <= '0;
                        rcvCnt   <= '0;
                        toCnt    <= '0;
                        lineBuf  <= '0;
                    end
                end
                FETCH: begin
                    if (reqValid && rd_reqReadyIn) begin
                        issueCnt <= issueCnt + 1'b1;
                    end
                    if (rd_rspValidIn) begin
                        lineBuf <= lineNext;
                        rcvCnt  <= rcvCnt + 1'b1;
                        toCnt   <= '0;
                        if (rcvCnt == LAST_BEAT_C) begin
                            rspTag  <= curTag;
                            rspLine <= lineNext;
                        end
                    end else begin
                        toCnt <= toCnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_rspTagOut          = rspTag;
    assign mem_rspInsLineOut      = rspLine;
    assign mem_rspInsLineValidOut = lineValid;
    assign rd_reqValidOut         = reqValid;
    assign rd_reqAddrOut          = reqAddr;
    assign refill_busyOut         = (state != IDLE);
    assign refill_errOut          = timeoutErr;

endmodule

// File: doc/ifu_refill_ctrl.md
Name: ifu_refill_ctrl

Overview:
- Miss-refill engine directly downstream of ifu_cache.
- Consumes the cache's line request (mem_reqTagOut/mem_reqTagValidOut), fetches the line as BEATS sequential word reads over a 32-bit valid/ready memory port, assembles a LINE_WIDTH line, and returns it as mem_rspTagIn/mem_rspInsLineIn/mem_rspInsLineValidIn.
- One refill in flight at a time, with a watchdog timeout.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- OFFSET_WIDTH, 4, line offset bits (16-byte line).
- TAG_WIDTH, 28, ADDR_WIDTH-OFFSET_WIDTH.
- LINE_WIDTH, 128, cache line width.
- WORD_WIDTH, 32, memory data width; BEATS=LINE_WIDTH/WORD_WIDTH (4), derived.
- TIMEOUT_CYCLES, 64, max cycles without a response beat before abort.

Ports:
- Clock in 1: single clock; reset is synchronous and active-high.
- Rst in 1: synchronous, active-high reset.
- cache_reqTagIn in TAG_WIDTH: miss tag from cache.
- cache_reqTagValidIn in 1: level-sensitive miss request.
- mem_rspTagOut out TAG_WIDTH: tag of returned line.
- mem_rspInsLineOut out LINE_WIDTH: assembled line.
- mem_rspInsLineValidOut out 1: one-cycle line-valid pulse.
- rd_reqValidOut out 1: word read request valid.
- rd_reqAddrOut out ADDR_WIDTH: word byte address.
- rd_reqReadyIn in 1: memory accepts request.
- rd_rspValidIn in 1: read data beat valid; in order, no backpressure.
- rd_rspDataIn in WORD_WIDTH: read data.
- refill_busyOut out 1: high in any state other than IDLE.
- refill_errOut out 1: one-cycle timeout pulse.

Behaviour:
- Reset: synchronous, evaluated at the rising edge.
  - All outputs 0.
  - State IDLE; issue, receive and timeout counters 0.
  - Line buffer 0.
- Reset mid-refill: abort immediately, drop the partial line, no valid or err pulse.
- States: IDLE, FETCH, DONE, HOLD.
- IDLE:
  - If cache_reqTagValidIn=1, latch cache_reqTagIn into cur_tag at the edge and go to FETCH.
  - Responses arriving in IDLE or HOLD are ignored.
- FETCH:
  - rd_reqValidOut=1 while issue_cnt<BEATS.
  - rd_reqAddrOut={cur_tag, issue_cnt[1:0], 2'b00}, i.e. word address.
  - issue_cnt increments on rd_reqValidOut&&rd_reqReadyIn.
  - Up to BEATS requests may be outstanding.
  - Each rd_rspValidIn writes rd_rspDataIn into line word rcv_cnt (word 0 at bits [31:0]), then rcv_cnt++.
  - The beat with rcv_cnt==BEATS-1 moves to DONE.
  - Request issue and response in the same cycle are both legal.
  - Changes on cache_reqTagIn while busy are ignored; the cache holds its request level, so different tags are re-presented later.
- DONE, exactly one cycle:
  - mem_rspInsLineValidOut=1, mem_rspTagOut=cur_tag, mem_rspInsLineOut=assembled line.
  - Next state HOLD.
- HOLD, exactly one cycle:
  - Requests ignored, giving the cache one cycle to insert and drop its miss.
  - Next state IDLE.
- Line and tag outputs hold their last values outside DONE. Only the valid strobe is a pulse.
- Latency (zero-wait memory, ready=1, 1-cycle read latency):
  - Request accepted at edge T.
  - Requests issue T+1..T+4.
  - Beats arrive T+2..T+5.
  - mem_rspInsLineValidOut high in cycle T+6.
  - Back in IDLE at T+8.
- Timeout:
  - In FETCH, to_cnt increments every cycle and clears on any rd_rspValidIn.
  - When to_cnt==TIMEOUT_CYCLES-1 and no beat arrives that cycle: refill_errOut=1 for one cycle, partial line discarded, no line valid, go to HOLD.
  - Late beats after the abort are ignored.
- rd_reqAddrOut is 0 whenever rd_reqValidOut=0.

Test Plan:
- Reset then request tag 0x0000100 (addr 0x1000), memory ready=1, 1-cycle latency, data 0xDEADBEEF per word:
  - Reads issued to 0x1000, 0x1004, 0x1008, 0x100C.
  - Single pulse with line 0xDEADBEEF×4 and tag 0x0000100 six cycles after accept.
  - busy low two cycles later.
- Word ordering: words 0x11111111, 0x22222222, 0x33333333, 0x44444444 for tag 0x0000FFF -> line 0x44444444_33333333_22222222_11111111.
- Backpressure: rd_reqReadyIn toggles 0/1 each cycle and rsp latency is 3 -> exactly 4 accepted requests, correct line, no duplicate addresses.
- Busy-time request: while refilling tag 0x10, cache_reqTagIn switches to 0x20 -> no new reads for 0x20 until HOLD ends; 0x20 refill starts from IDLE afterwards.
- Timeout: TIMEOUT_CYCLES=8, memory returns 2 beats then stops -> refill_errOut one-cycle pulse 8 cycles after the last beat, no mem_rspInsLineValidOut, later stray beats ignored, next request completes normally.
- Reset mid-refill: Rst asserted after 2 beats -> all outputs 0 next cycle, no pulse; a fresh request then completes correctly.
